// File: rtl/rrgrant.sv
// rrgrant: round-robin arbiter with a registered one-hot grant and a valid/ready handshake
module rrgrant #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] ack,
  output logic [N-1:0] sel,
  output logic         out_valid,
  input  logic         out_ready
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [N-1:0] sel_q, sel_d, cand, win;
  logic [2:0] ptr_q, ptr_d, gidx, base, idx;
  logic hs, upd, any;
  assign sel = sel_q;
  assign out_valid = state_q == GRANT;
  assign hs = out_valid & out_ready;
  assign ack = sel_q & {N{hs}};
  assign upd = !out_valid || hs;
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) gidx = sel_q[i] ? 3'(i) : gidx;
  end
  // The granted requester is masked only for the arbitration done in its handshake cycle.
  always_comb begin
    base = hs ? gidx + 3'd1 : ptr_q;
    cand = hs ? req & ~sel_q : req;
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = base + 3'(k);
      if (!any && cand[idx]) begin
        win[idx] = 1'b1;
        any = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = upd ? (any ? GRANT : IDLE) : state_q;
    sel_d = upd ? win : sel_q;
    ptr_d = hs ? gidx + 3'd1 : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: tb/tb_rrgrant.sv
// tb_rrgrant: directed and random checks of rrgrant against a behavioural round-robin model
module tb_rrgrant;
  logic clk = 0, rst = 0, out_ready = 0, out_valid;
  logic [7:0] req = 0, ack, sel;
  int tests = 0, fails = 0;
  int g = -1, mptr = 0;

  rrgrant dut (.clk(clk), .rst(rst), .req(req), .ack(ack), .sel(sel),
               .out_valid(out_valid), .out_ready(out_ready));

  always #5 clk = ~clk;

  function automatic int search(input logic [7:0] m, input int p);
    for (int k = 0; k < 8; k++)
      if (m[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle, compare against the model (and an optional literal sel), then advance.
  task automatic step(input logic [7:0] r, input logic rdy, input logic rs, input int lit = -1);
    logic [7:0] es, ea;
    logic ev;
    @(negedge clk);
    req = r; out_ready = rdy; rst = rs;
    #1;
    ev = g >= 0;
    es = ev ? 8'(1 << g) : 8'h00;
    ea = (ev && rdy) ? es : 8'h00;
    chk("sel", sel, es);
    chk("out_valid", {7'b0, out_valid}, {7'b0, ev});
    chk("ack", ack, ea);
    if (lit >= 0) chk("sel_literal", sel, 8'(lit));
    @(posedge clk);
    if (rs) begin
      g = -1; mptr = 0;
    end else if (g < 0) begin
      g = search(r, mptr);
    end else if (rdy) begin
      mptr = (g + 1) % 8;
      g = search(r & ~es, mptr);
    end
  endtask

  initial begin
    step(8'h00, 0, 1);
    step(8'h00, 0, 1);
    repeat (5) step(8'h00, 1, 0, 8'h00);
    step(8'h24, 1, 1);
    step(8'h24, 1, 0, 8'h00);
    step(8'h24, 1, 0, 8'h04);
    step(8'h24, 1, 0, 8'h20);
    step(8'h24, 1, 0, 8'h04);
    step(8'hFF, 0, 1);
    step(8'hFF, 1, 0, 8'h00);
    for (int i = 0; i < 9; i++) step(8'hFF, 1, 0, 1 << (i % 8));
    step(8'h00, 0, 1);
    step(8'h08, 0, 0, 8'h00);
    step(8'h08, 0, 0, 8'h08);
    step(8'h00, 0, 0, 8'h08);
    step(8'h00, 0, 0, 8'h08);
    step(8'h00, 0, 0, 8'h08);
    step(8'h00, 1, 0, 8'h08);
    step(8'h00, 1, 0, 8'h00);
    step(8'h10, 1, 1);
    step(8'h10, 1, 0, 8'h00);
    step(8'h10, 1, 0, 8'h10);
    step(8'h10, 1, 0, 8'h00);
    step(8'h10, 1, 0, 8'h10);
    step(8'h40, 0, 1);
    step(8'h40, 0, 0, 8'h00);
    step(8'hC0, 0, 1, 8'h40);
    step(8'hC0, 0, 0, 8'h00);
    step(8'hC0, 0, 0, 8'h40);
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(3) == 0) r = 8'h00;
      step(r, 1'($urandom_range(3) != 0), $urandom_range(40) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
